// File: rtl/led_pattern_gen.sv
// LED pattern engine: drives CHANNELS LEDs in one of four modes (binary
// count, bouncing scan, PWM breathe, alternating). A debounced push button
// advances the mode; a free-running prescaler paces the pattern steps.
module led_pattern_gen #(
   parameter int CHANNELS      = 8,
   parameter int PRESCALE_BITS = 22,
   parameter int DEBOUNCE_BITS = 16,
   parameter int PWM_BITS      = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn,
   output logic [CHANNELS-1:0] led,
   output logic [1:0]          mode,
   output logic                tick
);

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_ALT     = 2'd3
   } mode_t;

   localparam int POS_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(CHANNELS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [CHANNELS-1:0] LED_ONE  = CHANNELS'(1);

   // Repeating 01 pattern with bit 0 lit.
   function automatic logic [CHANNELS-1:0] alt_pattern();
      logic [CHANNELS-1:0] p;
      for (int i = 0; i < CHANNELS; i++) p[i] = (i % 2 == 0);
      return p;
   endfunction

   localparam logic [CHANNELS-1:0] ALT_PAT = alt_pattern();

   // Button path
   logic                     sync1, sync2, stable;
   logic [DEBOUNCE_BITS-1:0] db_cnt;
   logic                     press;

   // Timing
   logic [PRESCALE_BITS-1:0] prescaler;
   logic                     advance;
   logic [PWM_BITS-1:0]      pwm_cnt;

   // Pattern state
   mode_t               mode_q;
   logic [CHANNELS-1:0] step;
   logic [POS_W-1:0]    scan_pos;
   logic                scan_down;
   logic [PWM_BITS-1:0] duty;
   logic                duty_down;
   logic                phase;

   // A press is the cycle in which the debounced level is about to go 0->1.
   assign press   = sync2 && !stable && (db_cnt == '1);
   // Pattern step happens on the edge where the prescaler wraps to 0.
   assign advance = (prescaler == '1);
   assign mode    = mode_q;

   // Synchronise the raw button and debounce it into a stable level.
   // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block only.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         db_cnt <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (sync2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == '1) begin
            stable <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Free-running prescaler, step pulse and PWM counter (never cleared by mode changes).
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         tick      <= 1'b0;
         pwm_cnt   <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
         tick      <= advance;
         pwm_cnt   <= pwm_cnt + 1'b1;
      end
   end

   // Mode FSM and per-mode pattern state; a press clears state and overrides a step.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || press) begin
         mode_q    <= reset ? MODE_COUNT : mode_t'(mode_q + 2'd1);
         step      <= '0;
         scan_pos  <= '0;
         scan_down <= 1'b0;
         duty      <= '0;
         duty_down <= 1'b0;
         phase     <= 1'b0;
      end else if (advance) begin
         case (mode_q)
            MODE_COUNT: step <= step + 1'b1;
            MODE_SCAN: begin
               if (CHANNELS > 1) begin
                  if (!scan_down) begin
                     scan_pos <= scan_pos + POS_W'(1);
                     if (scan_pos == POS_MAX - POS_W'(1)) scan_down <= 1'b1;
                  end else begin
                     scan_pos <= scan_pos - POS_W'(1);
                     if (scan_pos == POS_W'(1)) scan_down <= 1'b0;
                  end
               end
            end
            MODE_BREATHE: begin
               if (!duty_down) begin
                  duty <= duty + 1'b1;
                  if (duty == DUTY_MAX - 1'b1) duty_down <= 1'b1;
               end else begin
                  duty <= duty - 1'b1;
                  if (duty == PWM_BITS'(1)) duty_down <= 1'b0;
               end
            end
            MODE_ALT: phase <= ~phase;
            default: ;
         endcase
      end
   end

   // Registered LED drive, one clock behind the pattern state it shows.
   always_ff @(posedge clk) begin
      if (reset) begin
         led <= '0;
      end else begin
         case (mode_q)
            MODE_COUNT:   led <= step;
            MODE_SCAN:    led <= LED_ONE << scan_pos;
            MODE_BREATHE: led <= {CHANNELS{pwm_cnt < duty}};
            MODE_ALT:     led <= phase ? ~ALT_PAT : ALT_PAT;
            default:      led <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a small configuration
// (4 LEDs, step every 4 clocks, 4-clock debounce, 2-bit PWM).
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;
   logic       tick;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] scan_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
   int         duty_exp [7] = '{1, 2, 3, 2, 1, 0, 1};

   led_pattern_gen #(
      .CHANNELS(4), .PRESCALE_BITS(2), .DEBOUNCE_BITS(2), .PWM_BITS(2)
   ) dut (
      .clk(clk), .reset(reset), .btn(btn), .led(led), .mode(mode), .tick(tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock, ending at the falling edge where outputs are sampled.
   task automatic step_clk();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Wait until tick is high (possibly already), then one more clock so led shows the step.
   task automatic wait_tick(output int gap);
      int n = 0;
      while (tick !== 1'b1 && n < 20) begin
         step_clk();
         n++;
      end
      if (n >= 20) begin
         $display("FAIL tick_timeout: no tick within 20 clocks");
         n_bad++;
      end
      n_cmp++;
      step_clk();
      gap = n + 1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      btn   = 1'b0;
      step_clk();
      step_clk();
      reset = 1'b0;
   endtask

   // Hold the button until the mode changes, then one more clock.
   task automatic do_press(input bit hold, input logic [1:0] exp_mode);
      logic [1:0] old = mode;
      int n = 0;
      btn = 1'b1;
      while (mode === old && n < 20) begin
         step_clk();
         n++;
      end
      n_cmp++;
      if (mode !== exp_mode) begin
         $display("FAIL press_mode: got %0d want %0d", mode, exp_mode);
         n_bad++;
      end
      step_clk();
      if (!hold) btn = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      step_clk();
      n_cmp++;
      if (led !== 4'b0000 || mode !== 2'd0 || tick !== 1'b0) begin
         $display("FAIL reset_state: led=%b mode=%0d tick=%b want 0000/0/0", led, mode, tick);
         n_bad++;
      end
      step_clk();
      reset = 1'b0;
   endtask

   task automatic test_count();
      int gap;
      for (int i = 1; i <= 16; i++) begin
         wait_tick(gap);
         if (i > 1) begin
            n_cmp++;
            if (gap != 4) begin
               $display("FAIL tick_period: got %0d clocks want 4", gap);
               n_bad++;
            end
         end
         n_cmp++;
         if (led !== 4'(i)) begin
            $display("FAIL count_led tick %0d: got %b want %b", i, led, 4'(i));
            n_bad++;
         end
      end
   endtask

   task automatic test_debounce();
      int changes = 0;
      logic [1:0] prev;
      btn = 1'b1;
      step_clk();
      step_clk();
      btn = 1'b0;
      repeat (10) step_clk();
      n_cmp++;
      if (mode !== 2'd0) begin
         $display("FAIL glitch_press: mode=%0d want 0", mode);
         n_bad++;
      end
      prev = mode;
      btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) btn = 1'b0;
         step_clk();
         if (mode !== prev) changes++;
         prev = mode;
      end
      n_cmp++;
      if (changes != 1 || mode !== 2'd1) begin
         $display("FAIL debounce_press: changes=%0d mode=%0d want 1/1", changes, mode);
         n_bad++;
      end
   endtask

   task automatic test_scan();
      int gap;
      apply_reset();
      do_press(1'b0, 2'd1);
      n_cmp++;
      if (led !== 4'b0001) begin
         $display("FAIL scan_entry: got %b want 0001", led);
         n_bad++;
      end
      for (int i = 0; i < 7; i++) begin
         wait_tick(gap);
         n_cmp++;
         if (led !== scan_exp[i]) begin
            $display("FAIL scan_step %0d: got %b want %b", i, led, scan_exp[i]);
            n_bad++;
         end
      end
   endtask

   task automatic test_breathe();
      int gap;
      int highs;
      bit uniform;
      do_press(1'b0, 2'd2);
      n_cmp++;
      if (led !== 4'b0000) begin
         $display("FAIL breathe_entry: got %b want 0000", led);
         n_bad++;
      end
      for (int i = 0; i < 7; i++) begin
         wait_tick(gap);
         highs   = 0;
         uniform = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (k > 0) step_clk();
            if (led === 4'b1111) highs++;
            else if (led !== 4'b0000) uniform = 1'b0;
         end
         n_cmp++;
         if (highs != duty_exp[i] || !uniform) begin
            $display("FAIL breathe_duty %0d: high %0d of 4 (uniform=%0d) want %0d", i, highs, uniform, duty_exp[i]);
            n_bad++;
         end
      end
   endtask

   task automatic test_alt_and_wrap();
      int gap;
      int n = 0;
      do_press(1'b0, 2'd3);
      n_cmp++;
      if (led !== 4'b0101) begin
         $display("FAIL alt_entry: got %b want 0101", led);
         n_bad++;
      end
      wait_tick(gap);
      n_cmp++;
      if (led !== 4'b1010) begin
         $display("FAIL alt_tick1: got %b want 1010", led);
         n_bad++;
      end
      wait_tick(gap);
      n_cmp++;
      if (led !== 4'b0101) begin
         $display("FAIL alt_tick2: got %b want 0101", led);
         n_bad++;
      end
      // Line the fourth press up with a step: button rises 3 clocks after a tick.
      repeat (10) step_clk();
      while (tick !== 1'b1 && n < 20) begin
         step_clk();
         n++;
      end
      step_clk();
      step_clk();
      btn = 1'b1;
      n = 0;
      while (mode === 2'd3 && n < 20) begin
         step_clk();
         n++;
      end
      n_cmp++;
      if (mode !== 2'd0 || tick !== 1'b1) begin
         $display("FAIL wrap_coincide: mode=%0d tick=%b want 0/1", mode, tick);
         n_bad++;
      end
      step_clk();
      n_cmp++;
      if (led !== 4'b0000) begin
         $display("FAIL wrap_led0: got %b want 0000", led);
         n_bad++;
      end
      step_clk();
      n_cmp++;
      if (led !== 4'b0000) begin
         $display("FAIL press_beats_tick: got %b want 0000", led);
         n_bad++;
      end
      btn = 1'b0;
      wait_tick(gap);
      n_cmp++;
      if (led !== 4'b0001) begin
         $display("FAIL wrap_led1: got %b want 0001", led);
         n_bad++;
      end
   endtask

   task automatic test_mid_reset();
      int gap;
      int changes = 0;
      apply_reset();
      do_press(1'b1, 2'd1);
      wait_tick(gap);
      wait_tick(gap);
      n_cmp++;
      if (led !== 4'b0100) begin
         $display("FAIL pre_reset_scan: got %b want 0100", led);
         n_bad++;
      end
      reset = 1'b1;
      btn   = 1'b0;
      step_clk();
      n_cmp++;
      if (led !== 4'b0000 || mode !== 2'd0 || tick !== 1'b0) begin
         $display("FAIL mid_reset: led=%b mode=%0d tick=%b want 0000/0/0", led, mode, tick);
         n_bad++;
      end
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step_clk();
         if (mode !== 2'd0) changes++;
      end
      n_cmp++;
      if (changes != 0) begin
         $display("FAIL spurious_press: mode nonzero in %0d clocks after reset want 0", changes);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_debounce();
      test_scan();
      test_breathe();
      test_alt_and_wrap();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
